// File: rtl/mul_arbiter_pkg.sv
// Shared types and constants for the multiplier arbiter: FSM encoding,
// operand/result widths and small index helpers.
package mul_arb_pkg;

  localparam int OPW  = 4;
  localparam int RESW = 8;

  typedef enum logic [2:0] {
    ST_FLUSH = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int tmo_cw(input int timeout);
    return $clog2(timeout);
  endfunction

  function automatic int rr_index(input int ptr, input int k, input int n);
    return (ptr + k) % n;
  endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Bus between the arbiter (master) and the single shared multiplier (slave).
interface mul_arbiter_if;
  import mul_arb_pkg::*;

  // m_start is a one-cycle request carrying m_a/m_b; the multiplier accepts it
  // when idle, drops m_ack, and raises m_ack with m_r valid when finished.
  // m_ack then stays high until the next accepted start.
  logic            m_start;
  logic [OPW-1:0]  m_a;
  logic [OPW-1:0]  m_b;
  logic [RESW-1:0] m_r;
  logic            m_ack;

  modport master (output m_start, output m_a, output m_b,
                  input  m_r,     input  m_ack);
  modport slave  (input  m_start, input  m_a, input  m_b,
                  output m_r,     output m_ack);

endinterface

// File: rtl/mul_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
module rr_pick
  import mul_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] sel,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  logic [IDXW-1:0] j;

  always_comb begin
    sel = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    // k runs 1..NREQ so the last served requester is considered last.
    for (int k = 1; k <= NREQ; k++) begin
      j = IDXW'(rr_index(int'(ptr), k, NREQ));
      if (!any && req[j]) begin
        any    = 1'b1;
        sel[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin sharing of one repeated-addition multiplier among NREQ
// requesters, with a startup flush and a watchdog that yields error completions.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [OPW*NREQ-1:0]  opa,
  input  logic [OPW*NREQ-1:0]  opb,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [RESW-1:0]      res,
  output logic                 err,
  mul_arbiter_if.master        mif,
  output state_t               dbg_state
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = tmo_cw(TIMEOUT);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [NREQ-1:0] own_oh_q, own_oh_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [RESW-1:0] res_q, res_d;
  logic            err_q, err_d;
  logic            m_start_q, m_start_d;
  logic [OPW-1:0]  m_a_q, m_a_d;
  logic [OPW-1:0]  m_b_q, m_b_d;

  logic [NREQ-1:0] pick_sel;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;
  logic [OPW-1:0]  opa_arr [NREQ];
  logic [OPW-1:0]  opb_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign opa_arr[i] = opa[i*OPW +: OPW];
    assign opb_arr[i] = opb[i*OPW +: OPW];
  end

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .sel (pick_sel),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    own_oh_d  = own_oh_q;
    gnt_d     = '0;
    done_d    = '0;
    res_d     = res_q;
    err_d     = err_q;
    m_start_d = 1'b0;
    m_a_d     = m_a_q;
    m_b_d     = m_b_q;
    case (state_q)
      ST_FLUSH: begin
        if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (pick_any) begin
          owner_d  = pick_idx;
          own_oh_d = pick_sel;
          m_a_d    = opa_arr[pick_idx];
          m_b_d    = opb_arr[pick_idx];
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        gnt_d     = own_oh_q;
        m_start_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // While our start is still on the bus, m_ack is the stale level of
        // the previous operation and must not be taken as completion.
        if (mif.m_ack && !m_start_q) begin
          res_d   = mif.m_r;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        done_d  = own_oh_q;
        ptr_d   = owner_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_FLUSH;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FLUSH;
      cnt_q     <= '0;
      ptr_q     <= IDXW'(NREQ - 1);
      owner_q   <= '0;
      own_oh_q  <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      m_start_q <= 1'b0;
      m_a_q     <= '0;
      m_b_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      own_oh_q  <= own_oh_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      res_q     <= res_d;
      err_q     <= err_d;
      m_start_q <= m_start_d;
      m_a_q     <= m_a_d;
      m_b_q     <= m_b_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign res         = res_q;
  assign err         = err_q;
  assign mif.m_start = m_start_q;
  assign mif.m_a     = m_a_q;
  assign mif.m_b     = m_b_q;
  assign dbg_state   = state_q;

endmodule
